ysyx_25020047_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the single-issue RV32E core. It steps each instruction through fetch, execute, memory and write-back. It handshakes with instruction memory and the LSU, and produces the IR-latch, register-file write-enable and PC-update strobes. These strobes gate the write-back unit's wdata/dnpc onto architectural state. It also detects ebreak, illegal instructions and bus timeouts, and keeps retire and cycle counters.

---
 rtl/ysyx_25020047_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_ysyx_25020047_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_seq_ctrl.sv
// Multi-cycle sequencer for the RV32E core: FETCH -> EXEC -> [MEM] -> WB, with
// halt detection (ebreak / illegal / bus timeout) and retire/cycle counters.
module ysyx_25020047_seq_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_rvalid,
    output logic             inst_latch,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             lsu_req,
    output logic             lsu_we,
    input  logic             lsu_done,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_retired,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] CODE_EBREAK  = 2'd1;
    localparam logic [1:0] CODE_ILLEGAL = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    // The wait counter holds the number of cycles already spent in the current
    // wait state, so the TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] wait_q;
    logic [1:0]  code_q;
    logic [1:0]  code_d;
    logic        ret_inc;
    logic        wait_hit;

    assign wait_hit = (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ret_inc = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (imem_rvalid) begin
                    state_d = S_EXEC;
                end else if (wait_hit) begin
                    state_d = S_HALT;
                    code_d  = CODE_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (dec_illegal || (dec_load && dec_store)) begin
                    state_d = S_HALT;
                    code_d  = CODE_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d = S_HALT;
                    code_d  = CODE_EBREAK;
                    ret_inc = 1'b1;
                end else if (dec_load || dec_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A completion in the last allowed cycle still wins over the timeout.
                if (lsu_done) begin
                    state_d = S_WB;
                end else if (wait_hit) begin
                    state_d = S_HALT;
                    code_d  = CODE_TIMEOUT;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                ret_inc = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            code_q       <= '0;
            inst_retired <= '0;
            cycle_cnt    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (state_q == S_FETCH || state_q == S_MEM) begin
                wait_q <= wait_q + 16'd1;
            end
            if (ret_inc) begin
                inst_retired <= inst_retired + 1'b1;
            end
            if (state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

    // Strobes decode from state only; rst masks them so an abort takes effect at once.
    assign imem_req   = !rst && (state_q == S_FETCH);
    assign lsu_req    = !rst && (state_q == S_MEM);
    assign lsu_we     = lsu_req && dec_store;
    assign pc_we      = !rst && (state_q == S_WB);
    assign rf_we      = pc_we && !dec_store;
    assign inst_latch = imem_req && imem_rvalid;

    assign halt      = (state_q == S_HALT);
    assign halt_code = code_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// Directed and randomized bench for ysyx_25020047_seq_ctrl; expected behaviour
// comes from a per-instruction transaction model (latency and counter arithmetic).
module tb_ysyx_25020047_seq_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_EBR  = 3;
    localparam int K_ILL  = 4;
    localparam int K_LDST = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic             imem_rvalid;
    logic             inst_latch;
    logic             dec_load;
    logic             dec_store;
    logic             dec_ebreak;
    logic             dec_illegal;
    logic             lsu_req;
    logic             lsu_we;
    logic             lsu_done;
    logic             rf_we;
    logic             pc_we;
    logic             halt;
    logic [1:0]       halt_code;
    logic [2:0]       state;
    logic [CNT_W-1:0] inst_retired;
    logic [CNT_W-1:0] cycle_cnt;

    int vectors = 0;
    int errs    = 0;
    int exp_ret = 0;
    int exp_cyc = 0;
    bit halted  = 1'b0;

    ysyx_25020047_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_rvalid  (imem_rvalid),
        .inst_latch   (inst_latch),
        .dec_load     (dec_load),
        .dec_store    (dec_store),
        .dec_ebreak   (dec_ebreak),
        .dec_illegal  (dec_illegal),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_done     (lsu_done),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .halt         (halt),
        .halt_code    (halt_code),
        .state        (state),
        .inst_retired (inst_retired),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_retired"}, inst_retired, 32'(exp_ret));
        chk({tag, "_cycles"}, cycle_cnt, 32'(exp_cyc));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_lsu_req"}, {31'd0, lsu_req}, 32'd0);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_pc_we"}, {31'd0, pc_we}, 32'd0);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        lsu_done    = 1'b1;
        dec_store   = 1'b1;
        #1;
        chk_quiet("rst");
        chk("rst_latch", {31'd0, inst_latch}, 32'd0);
        chk("rst_lsu_we", {31'd0, lsu_we}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_code", {30'd0, halt_code}, 32'd0);
        exp_ret = 0;
        exp_cyc = 0;
        halted  = 1'b0;
        chk_counters("rst");
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        lsu_done    = 1'b0;
        dec_store   = 1'b0;
    endtask

    task automatic expect_halt(input logic [1:0] code);
        halted = 1'b1;
        #1;
        chk("halt_state", {29'd0, state}, 32'd4);
        chk("halt_flag", {31'd0, halt}, 32'd1);
        chk("halt_code", {30'd0, halt_code}, {30'd0, code});
        chk_quiet("halt");
        chk_counters("halt");
    endtask

    task automatic idle(input int n, input logic [1:0] code);
        for (int i = 0; i < n; i++) begin
            imem_rvalid = 1'($urandom);
            lsu_done    = 1'($urandom);
            dec_load    = 1'($urandom);
            dec_store   = 1'($urandom);
            dec_ebreak  = 1'($urandom);
            dec_illegal = 1'($urandom);
            tick();
        end
        imem_rvalid = 1'b0;
        lsu_done    = 1'b0;
        chk("idle_halt", {31'd0, halt}, 32'd1);
        chk("idle_code", {30'd0, halt_code}, {30'd0, code});
        chk("idle_latch", {31'd0, inst_latch}, 32'd0);
        chk_quiet("idle");
        chk_counters("idle");
    endtask

    // One instruction as a transaction: fw idle fetch cycles before rvalid,
    // mw idle memory cycles before lsu_done; a wait >= TO means never arrives.
    task automatic run_inst(input int kind, input int fw, input int mw);
        bit is_ld;
        bit is_st;
        int nf;
        int nm;
        is_ld = (kind == K_LD) || (kind == K_LDST);
        is_st = (kind == K_ST) || (kind == K_LDST);
        nf    = (fw < TO) ? fw + 1 : TO;
        nm    = (mw < TO) ? mw + 1 : TO;
        for (int i = 0; i < nf; i++) begin
            imem_rvalid = (i == fw);
            dec_load    = 1'($urandom);
            dec_store   = 1'($urandom);
            dec_ebreak  = 1'($urandom);
            dec_illegal = 1'($urandom);
            #2;
            chk("fetch_state", {29'd0, state}, 32'd0);
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_latch", {31'd0, inst_latch}, {31'd0, (i == fw)});
            chk("fetch_lsu_req", {31'd0, lsu_req}, 32'd0);
            chk("fetch_pc_we", {31'd0, pc_we}, 32'd0);
            exp_cyc++;
            tick();
        end
        imem_rvalid = 1'b0;
        if (fw >= TO) begin
            expect_halt(2'd3);
            return;
        end
        dec_load    = is_ld;
        dec_store   = is_st;
        dec_ebreak  = (kind == K_EBR) || (kind == K_ILL && $urandom_range(0, 1) == 1);
        dec_illegal = (kind == K_ILL);
        if (kind == K_EBR || kind == K_ILL) dec_load = 1'($urandom);
        #2;
        chk("exec_state", {29'd0, state}, 32'd1);
        chk_quiet("exec");
        exp_cyc++;
        tick();
        if (kind == K_ILL || kind == K_LDST) begin
            expect_halt(2'd2);
            return;
        end
        if (kind == K_EBR) begin
            exp_ret++;
            expect_halt(2'd1);
            return;
        end
        if (is_ld || is_st) begin
            for (int j = 0; j < nm; j++) begin
                lsu_done = (j == mw);
                #2;
                chk("mem_state", {29'd0, state}, 32'd2);
                chk("mem_lsu_req", {31'd0, lsu_req}, 32'd1);
                chk("mem_lsu_we", {31'd0, lsu_we}, {31'd0, is_st});
                chk("mem_imem_req", {31'd0, imem_req}, 32'd0);
                chk("mem_rf_we", {31'd0, rf_we}, 32'd0);
                exp_cyc++;
                tick();
            end
            lsu_done = 1'b0;
            if (mw >= TO) begin
                expect_halt(2'd3);
                return;
            end
        end
        #2;
        chk("wb_state", {29'd0, state}, 32'd3);
        chk("wb_pc_we", {31'd0, pc_we}, 32'd1);
        chk("wb_rf_we", {31'd0, rf_we}, {31'd0, !is_st});
        chk("wb_lsu_req", {31'd0, lsu_req}, 32'd0);
        chk("wb_imem_req", {31'd0, imem_req}, 32'd0);
        exp_cyc++;
        exp_ret++;
        tick();
        chk("retire_state", {29'd0, state}, 32'd0);
        chk("retire_halt", {31'd0, halt}, 32'd0);
        chk_counters("retire");
    endtask

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        lsu_done    = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_ebreak  = 1'b0;
        dec_illegal = 1'b0;
        tick();

        // Zero-wait ALU instruction: three cycles, one retirement.
        do_reset();
        run_inst(K_ALU, 0, 0);
        chk("t1_retired", inst_retired, 32'd1);
        chk("t1_cycles", cycle_cnt, 32'd3);

        // Load completing on the third memory cycle: six cycles from reset.
        do_reset();
        run_inst(K_LD, 0, 2);
        chk("t2_cycles", cycle_cnt, 32'd6);

        // Zero-wait store, then ebreak halting with frozen counters.
        run_inst(K_ST, 0, 0);
        chk("t3_retired", inst_retired, 32'd2);
        run_inst(K_EBR, 0, 0);
        idle(20, 2'd1);

        do_reset();
        run_inst(K_ILL, 1, 0);
        idle(5, 2'd2);
        do_reset();
        run_inst(K_LDST, 0, 0);
        idle(3, 2'd2);

        // Memory timeout, then done on the final permitted cycle, then fetch timeout.
        do_reset();
        run_inst(K_LD, 0, TO + 3);
        idle(4, 2'd3);
        do_reset();
        run_inst(K_ST, 0, TO - 1);
        run_inst(K_LD, TO - 1, TO - 1);
        run_inst(K_ALU, TO + 2, 0);
        idle(4, 2'd3);

        // Reset while a load is waiting in the memory state.
        do_reset();
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        dec_load    = 1'b1;
        dec_store   = 1'b0;
        dec_ebreak  = 1'b0;
        dec_illegal = 1'b0;
        tick();
        lsu_done = 1'b0;
        tick();
        #2;
        chk("t6_lsu_req_before", {31'd0, lsu_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_lsu_req_after", {31'd0, lsu_req}, 32'd0);
        chk("t6_rf_we", {31'd0, rf_we}, 32'd0);
        chk("t6_state", {29'd0, state}, 32'd0);
        chk("t6_retired", inst_retired, 32'd0);
        chk("t6_cycles", cycle_cnt, 32'd0);
        tick();
        rst     = 1'b0;
        exp_ret = 0;
        exp_cyc = 0;
        run_inst(K_ALU, 1, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            int r;
            int fw;
            int mw;
            int kind;
            if (halted) do_reset();
            r  = $urandom_range(0, 19);
            fw = $urandom_range(0, TO - 1);
            mw = $urandom_range(0, TO);
            if (r <= 5)       kind = K_ALU;
            else if (r <= 10) kind = K_LD;
            else if (r <= 15) kind = K_ST;
            else if (r == 16) kind = K_EBR;
            else if (r == 17) kind = K_ILL;
            else if (r == 18) kind = K_LDST;
            else begin
                kind = K_ALU;
                fw   = TO + 1;
            end
            run_inst(kind, fw, mw);
            if (halted) idle(2, halt_code_exp(kind, fw, mw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    function automatic logic [1:0] halt_code_exp(input int kind, input int fw, input int mw);
        if (fw >= TO) return 2'd3;
        if (kind == K_ILL || kind == K_LDST) return 2'd2;
        if (kind == K_EBR) return 2'd1;
        if (mw >= TO) return 2'd3;
        return 2'd0;
    endfunction

endmodule
